// File: rtl/timer_ctrl.sv
// Control FSM for the countdown timer: synchronizes operator buttons, sequences
// load/run/pause/alarm/fault, and drives the datapath load strobe and count enable.
module timer_ctrl #(
   parameter int ALARM_SECS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_set,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       done,
   input  logic       err,
   output logic       load,
   output logic       ce,
   output logic       alarm,
   output logic       fault,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      ALARM = 3'd4,
      FAULT = 3'd5
   } state_t;

   localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SECS);

   state_t     cur_state;
   state_t     nxt_state;
   logic       nxt_alarm;
   logic [7:0] alarm_cnt;
   logic [7:0] nxt_cnt;

   // bit 0 = set, bit 1 = start, bit 2 = pause
   logic [2:0] btn_raw;
   logic [2:0] sync1;
   logic [2:0] sync2;
   logic [2:0] hist;
   logic [2:0] btn_edge;
   logic       set_edge;
   logic       start_edge;
   logic       pause_edge;
   logic       any_edge;

   assign btn_raw    = {btn_pause, btn_start, btn_set};
   assign btn_edge   = sync2 & ~hist;
   assign set_edge   = btn_edge[0];
   assign start_edge = btn_edge[1];
   assign pause_edge = btn_edge[2];
   assign any_edge   = |btn_edge;

   // Two-flop synchronizer plus history flop for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 3'b000;
         sync2 <= 3'b000;
         hist  <= 3'b000;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   // Next-state, alarm toggle and alarm-counter decode
   always_comb begin
      nxt_state = cur_state;
      nxt_alarm = 1'b0;
      nxt_cnt   = 8'd0;
      case (cur_state)
         IDLE: begin
            if (set_edge) begin
               nxt_state = LOAD;
            end else if (start_edge && !done && !err) begin
               nxt_state = RUN;
            end else begin
               nxt_state = IDLE;
            end
         end
         LOAD: begin
            nxt_state = IDLE;
         end
         RUN: begin
            if (err) begin
               nxt_state = FAULT;
            end else if (done) begin
               nxt_state = ALARM;
               nxt_alarm = 1'b1;
               nxt_cnt   = 8'd0;
            end else if (start_edge || pause_edge) begin
               nxt_state = PAUSE;
            end else begin
               nxt_state = RUN;
            end
         end
         PAUSE: begin
            if (err) begin
               nxt_state = FAULT;
            end else if (set_edge) begin
               nxt_state = LOAD;
            end else if (start_edge) begin
               nxt_state = RUN;
            end else begin
               nxt_state = PAUSE;
            end
         end
         ALARM: begin
            // any button acknowledges the alarm; otherwise it times out on ticks
            if (any_edge) begin
               nxt_state = IDLE;
            end else if (tick) begin
               if (alarm_cnt + 8'd1 == ALARM_LIMIT) begin
                  nxt_state = IDLE;
               end else begin
                  nxt_state = ALARM;
                  nxt_alarm = ~alarm;
                  nxt_cnt   = alarm_cnt + 8'd1;
               end
            end else begin
               nxt_state = ALARM;
               nxt_alarm = alarm;
               nxt_cnt   = alarm_cnt;
            end
         end
         FAULT: begin
            if (set_edge) begin
               nxt_state = LOAD;
            end else begin
               nxt_state = FAULT;
            end
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   // State register and registered outputs decoded from next-state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= IDLE;
         load      <= 1'b0;
         fault     <= 1'b0;
         alarm     <= 1'b0;
         alarm_cnt <= 8'd0;
      end else begin
         cur_state <= nxt_state;
         load      <= (nxt_state == LOAD);
         fault     <= (nxt_state == FAULT);
         alarm     <= nxt_alarm;
         alarm_cnt <= nxt_cnt;
      end
   end

   assign ce    = tick & (cur_state == RUN);
   assign state = cur_state;

endmodule
